axis_packet_fifo: RTL and testbench

AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

---
 rtl/tcp_stack_pkg.sv | 19 +
 rtl/sdp_ram.sv | 34 +++
 rtl/axis_packet_fifo.sv | 118 +++++++++++
 tb/tb_axis_packet_fifo.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_stack_pkg.sv
// Shared constants and helpers for the stream-buffering blocks.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package tcp_stack_pkg;

  localparam int DEFAULT_DATA_BITS = 512;
  localparam int DEFAULT_DEPTH     = 1024;

  // Ceiling log2 usable in parameter defaults.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data appears the cycle after i_rd_en.
// Backpressure: none; o_rd_dat holds its value while i_rd_en is low.
module sdp_ram
  import tcp_stack_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_DATA_BITS + DEFAULT_DATA_BITS / 8 + 1,
  parameter int ADDR_BITS = clog2(DEFAULT_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]     i_wr_dat,
  input  logic                 i_rd_en,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [WIDTH-1:0]     o_rd_dat
);

  logic [WIDTH-1:0] r_mem [2**ADDR_BITS];
  logic [WIDTH-1:0] r_rd_dat;

  // Write port: no reset so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  // Read port register; holds the last word read while idle.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) r_rd_dat <= r_mem[i_rd_addr];
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI-Stream FIFO with optional store-and-forward on tlast, BRAM-backed.
// Latency: word written in cycle N is valid on the master side in cycle N+2.
// Backpressure: s_axis_tready registered from level; output register stalls on m_axis_tready=0.
module axis_packet_fifo
  import tcp_stack_pkg::*;
#(
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ADDR_BITS    = clog2(DEPTH),
  parameter int PACKET_MODE  = 0,
  parameter int AFULL_THRESH = DEPTH - 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [ADDR_BITS:0]     level,
  output logic                   almost_full,
  output logic [ADDR_BITS:0]     pkt_count
);

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int WORD_BITS = DATA_BITS + KEEP_BITS + 1;
  localparam int LVL_BITS  = ADDR_BITS + 1;
  localparam logic [ADDR_BITS:0] LP_FULL  = LVL_BITS'(DEPTH);
  localparam logic [ADDR_BITS:0] LP_AFULL = LVL_BITS'(AFULL_THRESH);
  localparam logic               LP_PKT   = (PACKET_MODE != 0);

  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_level;
  logic [ADDR_BITS:0]   r_pkt_count;
  logic                 r_s_tready;
  logic                 r_afull;
  logic                 r_out_vld;
  logic                 r_pulled;      // output register was loaded last cycle
  logic                 r_any_loaded;  // RAM read register holds a real word

  logic                 w_wr;
  logic                 w_pull;
  logic                 w_pull_ok;
  logic                 w_rd_last;
  logic                 w_mid_pkt;
  logic                 w_pkt_dec;
  logic [ADDR_BITS:0]   w_pkt_eff;
  logic [ADDR_BITS:0]   w_pkt_nxt;
  logic [ADDR_BITS:0]   w_level_nxt;
  logic [WORD_BITS-1:0] w_rd_word;

  sdp_ram #(
    .WIDTH     (WORD_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_dat  ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .i_rd_en   (w_pull),
    .i_rd_addr (r_rd_ptr),
    .o_rd_dat  (w_rd_word)
  );

  assign w_wr      = s_axis_tvalid && r_s_tready;
  // The RAM read register doubles as the output register, so the tlast of the
  // word loaded last cycle is only visible now; the packet count settles here.
  assign w_rd_last = w_rd_word[WORD_BITS-1];
  assign w_pkt_dec = r_pulled && w_rd_last;
  assign w_pkt_eff = r_pkt_count - LVL_BITS'(w_pkt_dec);
  assign w_mid_pkt = r_any_loaded && !w_rd_last;
  // Full memory always drains so an oversize packet cannot deadlock.
  assign w_pull_ok = !LP_PKT || (w_pkt_eff != '0) || w_mid_pkt || (r_level == LP_FULL);
  assign w_pull    = (r_level != '0) && w_pull_ok && (!r_out_vld || m_axis_tready);

  assign w_level_nxt = r_level + LVL_BITS'(w_wr) - LVL_BITS'(w_pull);
  assign w_pkt_nxt   = w_pkt_eff + LVL_BITS'(w_wr && s_axis_tlast);

  // Pointers, occupancy, flow-control flags and output-register valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_pkt_count  <= '0;
      r_s_tready   <= 1'b0;
      r_afull      <= 1'b0;
      r_out_vld    <= 1'b0;
      r_pulled     <= 1'b0;
      r_any_loaded <= 1'b0;
    end else begin
      if (w_wr)   r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
      if (w_pull) r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
      r_level      <= w_level_nxt;
      r_pkt_count  <= w_pkt_nxt;
      r_s_tready   <= (w_level_nxt < LP_FULL);
      r_afull      <= (w_level_nxt >= LP_AFULL);
      r_out_vld    <= w_pull || (r_out_vld && !m_axis_tready);
      r_pulled     <= w_pull;
      if (w_pull) r_any_loaded <= 1'b1;
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tvalid = r_out_vld;
  // Data is masked while empty so reset and idle present zeros.
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = r_out_vld ? w_rd_word : '0;
  assign level         = r_level;
  assign almost_full   = r_afull;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: streaming and packet-mode instances side by side.
// Scoreboard queues hold every accepted word; each delivered word must match the head.
// Directed steps plus a random-traffic phase, all from one initial block.
module tb_axis_packet_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata  [2];
  logic [3:0]  s_tkeep  [2];
  logic        s_tlast  [2];
  logic        s_tvalid [2];
  logic        s_tready [2];
  logic [31:0] m_tdata  [2];
  logic [3:0]  m_tkeep  [2];
  logic        m_tlast  [2];
  logic        m_tvalid [2];
  logic        m_tready [2];
  logic [4:0]  level    [2];
  logic        afull    [2];
  logic [4:0]  pkt      [2];

  int          n_cmp;
  int          n_err;
  logic [36:0] q0 [$];
  logic [36:0] q1 [$];
  int          acc   [2];
  logic        fired [2];

  always #5 clk = ~clk;

  axis_packet_fifo #(
    .DATA_BITS(32), .DEPTH(16), .ADDR_BITS(4), .PACKET_MODE(0), .AFULL_THRESH(12)
  ) u_fifo0 (
    .clk(clk), .reset(rst),
    .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tlast(s_tlast[0]),
    .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tlast(m_tlast[0]),
    .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .level(level[0]), .almost_full(afull[0]), .pkt_count(pkt[0])
  );

  axis_packet_fifo #(
    .DATA_BITS(32), .DEPTH(16), .ADDR_BITS(4), .PACKET_MODE(1), .AFULL_THRESH(12)
  ) u_fifo1 (
    .clk(clk), .reset(rst),
    .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tlast(s_tlast[1]),
    .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tlast(m_tlast[1]),
    .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .level(level[1]), .almost_full(afull[1]), .pkt_count(pkt[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A delivered word must be the oldest accepted word not yet delivered.
  task automatic sb_out(input int d, input logic [36:0] w);
    logic [36:0] e;
    if (d == 0) begin
      chk("sb0_nonempty", 64'(q0.size() > 0), 64'd1);
      if (q0.size() > 0) begin e = q0.pop_front(); chk("sb0_word", 64'(w), 64'(e)); end
    end else begin
      chk("sb1_nonempty", 64'(q1.size() > 0), 64'd1);
      if (q1.size() > 0) begin e = q1.pop_front(); chk("sb1_word", 64'(w), 64'(e)); end
    end
  endtask

  // One clock: record handshakes seen before the edge, then update the model.
  task automatic step();
    logic        in_f  [2];
    logic        out_f [2];
    logic [36:0] in_w  [2];
    logic [36:0] out_w [2];
    logic        was_rst;
    was_rst = rst;
    for (int d = 0; d < 2; d++) begin
      in_f[d]  = s_tvalid[d] && s_tready[d];
      in_w[d]  = {s_tlast[d], s_tkeep[d], s_tdata[d]};
      out_f[d] = m_tvalid[d] && m_tready[d];
      out_w[d] = {m_tlast[d], m_tkeep[d], m_tdata[d]};
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      q0.delete();
      q1.delete();
      fired[0] = 1'b0;
      fired[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        fired[d] = (in_f[d] === 1'b1);
        if (fired[d]) begin
          acc[d]++;
          if (d == 0) q0.push_back(in_w[d]); else q1.push_back(in_w[d]);
        end
        if (out_f[d] === 1'b1) sb_out(d, out_w[d]);
      end
    end
  endtask

  task automatic drive(input int d, input logic last);
    s_tdata[d]  = $urandom;
    s_tkeep[d]  = 4'($urandom_range(0, 15));
    s_tlast[d]  = last;
    s_tvalid[d] = 1'b1;
  endtask

  task automatic chk_reset_vals(input int d);
    chk("rst_ctl", 64'({m_tvalid[d], m_tlast[d], m_tkeep[d], s_tready[d], afull[d]}), 64'd0);
    chk("rst_dat", 64'(m_tdata[d]), 64'd0);
    chk("rst_cnt", 64'({level[d], pkt[d]}), 64'd0);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      step();
    end
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
  endtask

  initial begin
    int base;
    int nacc;
    int exp_lvl;
    int n;
    int mx;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      s_tdata[d] = '0; s_tkeep[d] = '0; s_tlast[d] = 1'b0; s_tvalid[d] = 1'b0;
      m_tready[d] = 1'b0; acc[d] = 0; fired[d] = 1'b0;
    end

    // Reset values, then ready one cycle after release.
    repeat (3) step();
    for (int d = 0; d < 2; d++) chk_reset_vals(d);
    rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++) chk("tready_after_rst", 64'(s_tready[d]), 64'd1);

    // Single word, cycle N write, valid in N+2.
    m_tready[0] = 1'b1;
    s_tdata[0] = 32'hA5A5A5A5; s_tkeep[0] = 4'hF; s_tlast[0] = 1'b1; s_tvalid[0] = 1'b1;
    step();
    s_tvalid[0] = 1'b0;
    chk("sw_vld_n1", 64'(m_tvalid[0]), 64'd0);
    chk("sw_lvl_n1", 64'(level[0]), 64'd1);
    step();
    chk("sw_vld_n2", 64'(m_tvalid[0]), 64'd1);
    chk("sw_dat_n2", 64'(m_tdata[0]), 64'hA5A5A5A5);
    chk("sw_lvl_n2", 64'(level[0]), 64'd0);
    step();
    chk("sw_empty", 64'({m_tvalid[0], level[0]}), 64'd0);

    // Fill with the reader stalled: memory holds 16 and the output register
    // one more, so the 17th accepted word closes tready; later writes are ignored.
    m_tready[0] = 1'b0;
    base = acc[0];
    for (int i = 1; i <= 19; i++) begin
      drive(0, 1'b0);
      step();
      nacc    = acc[0] - base;
      exp_lvl = nacc - ((i >= 2) ? 1 : 0);
      chk("fill_lvl", 64'(level[0]), 64'(exp_lvl));
      chk("fill_afull", 64'(afull[0]), 64'(exp_lvl >= 12));
    end
    s_tvalid[0] = 1'b0;
    chk("fill_acc", 64'(acc[0] - base), 64'd17);
    chk("fill_tready", 64'(s_tready[0]), 64'd0);
    m_tready[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (q0.size() == 0) break;
      step();
      n++;
    end
    chk("fill_drain_cyc", 64'(n), 64'd17);
    chk("fill_lvl_end", 64'(level[0]), 64'd0);

    // Continuous streaming, 40 words, wraps the pointers several times.
    for (int i = 1; i <= 40; i++) begin
      drive(0, 1'($urandom_range(0, 1)));
      step();
      chk("str_lvl", 64'(level[0]), 64'd1);
      if (i >= 2) chk("str_vld", 64'(m_tvalid[0]), 64'd1);
    end
    s_tvalid[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (q0.size() == 0) break;
      step();
      n++;
    end
    chk("str_tail", 64'(n), 64'd2);
    chk("str_idle", 64'(m_tvalid[0]), 64'd0);

    // Packet mode: five words held until tlast, then back-to-back.
    m_tready[1] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1'(i == 5));
      step();
      chk("pkt_hold", 64'(m_tvalid[1]), 64'd0);
    end
    s_tvalid[1] = 1'b0;
    chk("pkt_cnt1", 64'(pkt[1]), 64'd1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("pkt_b2b", 64'(m_tvalid[1]), 64'd1);
    end
    step();
    chk("pkt_done", 64'(m_tvalid[1]), 64'd0);
    step();
    chk("pkt_cnt0", 64'(pkt[1]), 64'd0);

    // Oversize packet: memory must fill and drain through the fallback.
    mx = 0;
    for (int w = 1; w <= 20; w++) begin
      drive(1, 1'(w == 20));
      for (int b = 0; b < 50; b++) begin
        step();
        if (int'(level[1]) > mx) mx = int'(level[1]);
        if (fired[1]) break;
      end
      chk("ovs_accept", 64'(fired[1]), 64'd1);
    end
    s_tvalid[1] = 1'b0;
    chk("ovs_full", 64'(mx), 64'd16);
    drain(60);
    chk("ovs_cnt0", 64'(pkt[1]), 64'd0);

    // Reset part-way through a packet on both instances.
    m_tready[0] = 1'b0;
    m_tready[1] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1'b0);
      drive(1, 1'b0);
      step();
    end
    chk("pre_rst_vld0", 64'(m_tvalid[0]), 64'd1);
    chk("pre_rst_hold1", 64'(m_tvalid[1]), 64'd0);
    rst = 1'b1;
    step();
    for (int d = 0; d < 2; d++) chk_reset_vals(d);
    rst = 1'b0;
    s_tvalid[0] = 1'b0; s_tvalid[1] = 1'b0;
    m_tready[0] = 1'b1; m_tready[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_quiet", 64'({m_tvalid[1], m_tvalid[0]}), 64'd0);
    end
    drive(0, 1'b1);
    drive(1, 1'b0);
    step();
    drive(1, 1'b1);
    s_tvalid[0] = 1'b0;
    step();
    s_tvalid[1] = 1'b0;
    drain(20);

    // Random traffic on both instances.
    mx = 0;
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (!s_tvalid[d] || fired[d]) begin
          if ($urandom_range(0, 1) == 1) drive(d, 1'($urandom_range(0, 3) == 0));
          else s_tvalid[d] = 1'b0;
        end
        m_tready[d] = ($urandom_range(0, 3) != 0);
      end
      step();
      if (int'(level[0]) > mx) mx = int'(level[0]);
      if (int'(level[1]) > mx) mx = int'(level[1]);
    end
    chk("rnd_max_lvl", 64'(mx <= 16), 64'd1);
    m_tready[0] = 1'b1;
    m_tready[1] = 1'b1;
    s_tvalid[0] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!(s_tvalid[1] && !fired[1])) break;
      step();
    end
    drive(1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step();
      if (fired[1]) break;
    end
    chk("rnd_close", 64'(fired[1]), 64'd1);
    s_tvalid[1] = 1'b0;
    drain(100);
    step();
    chk("rnd_end", 64'({m_tvalid[1], m_tvalid[0], level[1], level[0]}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
